// File: rtl/dft_cos_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dft_cos_arbiter
// Description : Round-robin arbiter/scheduler sharing one pipelined, stallable
//               single-precision cosine unit among NREQ requesters. Tracks
//               requester IDs in a shadow {valid,id} pipe of depth LAT that
//               advances in lockstep with the unit, and returns results on a
//               valid/ready response port. Response back-pressure freezes the
//               unit through astall.
//               Optional feature macro: DFT_COS_ARB_PERF_EN adds the
//               perf_issue / perf_stall event counters.
// Revision    : 1.0 - initial release
// ============================================================================
module dft_cos_arbiter #(
    parameter int NREQ = 4,
    parameter int LAT  = 2,
    parameter int IDW  = 3
) (
    input  logic                 aclk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_data,
    output logic                 a_sign,
    output logic [7:0]           a_exp,
    output logic [22:0]          a_man,
    output logic                 astall,
    input  logic [36:0]          x,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
`ifdef DFT_COS_ARB_PERF_EN
    output logic [31:0]          perf_issue,
    output logic [31:0]          perf_stall,
`endif
    output logic [36:0]          rsp_x
);

    localparam int C_TAIL = LAT - 1;

    // Shadow pipe mirroring the cosine unit's internal registers
    logic           r_sv  [LAT];
    logic [IDW-1:0] r_sid [LAT];
    logic [IDW-1:0] r_rr_ptr;

    logic           w_found;
    logic           w_issue;
    logic [IDW-1:0] w_gnt;
    logic [IDW-1:0] w_ptr_nxt;
    logic [IDW:0]   w_sum;
    logic [31:0]    w_op;

    // The tail stage drives the response port directly; only a valid,
    // unaccepted result may freeze the unit.
    assign rsp_valid = r_sv[C_TAIL];
    assign rsp_id    = r_sid[C_TAIL];
    assign rsp_x     = x;
    assign astall    = r_sv[C_TAIL] & ~rsp_ready;

    // Round-robin search: first valid requester at or after r_rr_ptr, wrapping
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_sum   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (IDW+1)'(k);
            if (w_sum >= (IDW+1)'(NREQ)) begin
                w_sum = w_sum - (IDW+1)'(NREQ);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!w_found && req_valid[i] && (w_sum == (IDW+1)'(i))) begin
                    w_found = 1'b1;
                    w_gnt   = IDW'(i);
                end
            end
        end
    end

    // A grant is only issued while the unit is free to advance
    assign w_issue   = w_found & ~astall;
    assign w_ptr_nxt = (w_gnt == IDW'(NREQ-1)) ? '0 : (w_gnt + 1'b1);

    // One-hot accept and operand mux for the granted requester
    always_comb begin
        req_ready = '0;
        w_op      = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_issue && (w_gnt == IDW'(i))) begin
                req_ready[i] = 1'b1;
                w_op         = req_data[32*i +: 32];
            end
        end
    end

    assign a_sign = w_op[31];
    assign a_exp  = w_op[30:23];
    assign a_man  = w_op[22:0];

    // Shadow pipe and round-robin pointer; both hold while the unit is stalled
    always_ff @(posedge aclk) begin
        if (!rst_n) begin
            for (int s = 0; s < LAT; s++) begin
                r_sv[s]  <= 1'b0;
                r_sid[s] <= '0;
            end
            r_rr_ptr <= '0;
        end else if (!astall) begin
            r_sv[0]  <= w_issue;
            r_sid[0] <= w_issue ? w_gnt : '0;
            for (int s = 1; s < LAT; s++) begin
                r_sv[s]  <= r_sv[s-1];
                r_sid[s] <= r_sid[s-1];
            end
            if (w_issue) begin
                r_rr_ptr <= w_ptr_nxt;
            end
        end
    end

`ifdef DFT_COS_ARB_PERF_EN
    logic [31:0] r_perf_issue;
    logic [31:0] r_perf_stall;

    // Free-running event counters for issued operands and stalled cycles
    always_ff @(posedge aclk) begin
        if (!rst_n) begin
            r_perf_issue <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_issue) begin
                r_perf_issue <= r_perf_issue + 32'd1;
            end
            if (astall) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_issue = r_perf_issue;
    assign perf_stall = r_perf_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dft_cos_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dft_cos_arbiter
// Description : Scoreboard bench for dft_cos_arbiter with a stallable model of
//               the cosine unit and a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dft_cos_arbiter;

    localparam int NREQ = 4;
    localparam int LAT  = 2;
    localparam int IDW  = 3;

    logic                aclk;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [32*NREQ-1:0]  req_data;
    logic                a_sign;
    logic [7:0]          a_exp;
    logic [22:0]         a_man;
    logic                astall;
    logic [36:0]         x;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [36:0]         rsp_x;

    dft_cos_arbiter #(.NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
        .aclk      (aclk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .a_sign    (a_sign),
        .a_exp     (a_exp),
        .a_man     (a_man),
        .astall    (astall),
        .x         (x),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_x     (rsp_x)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // Stand-in for the cosine unit: deterministic scrambling of the operand
    function automatic logic [36:0] fcos(input logic [31:0] a);
        return {a[31:27] ^ 5'h0B, a ^ 32'h5A3C_96E1};
    endfunction

    // Stallable, registered-output unit model with LAT enabled stages
    logic [36:0] upipe [LAT];
    always @(posedge aclk) begin
        if (!astall) begin
            upipe[0] <= fcos({a_sign, a_exp, a_man});
            for (int s = 1; s < LAT; s++) upipe[s] <= upipe[s-1];
        end
    end
    assign x = upipe[LAT-1];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: in-flight results as a FIFO stamped with the count of
    // non-stalled cycles at issue; a result is due LAT enabled cycles later.
    typedef struct {
        logic [IDW-1:0] id;
        logic [36:0]    xv;
        longint         e;
    } item_t;

    item_t  sbq[$];
    int     ptr_m    = 0;
    longint en_cnt   = 0;
    bit     model_ok = 1'b0;

    function automatic bit exp_valid();
        return (sbq.size() > 0) && (sbq[0].e + LAT == en_cnt);
    endfunction

    function automatic int exp_grant(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (ptr_m + k) % NREQ;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Monitor: compare every DUT output against the model away from the edge
    initial forever begin
        @(negedge aclk);
        if (model_ok) begin
            bit ev, es;
            int g;
            logic [NREQ-1:0] er;
            logic [31:0] ea;
            ev = exp_valid();
            es = ev && !rsp_ready;
            chk("astall", 64'(astall), 64'(es));
            chk("rsp_valid", 64'(rsp_valid), 64'(ev));
            if (ev) begin
                chk("rsp_id", 64'(rsp_id), 64'(sbq[0].id));
                chk("rsp_x", 64'(rsp_x), 64'(sbq[0].xv));
            end else begin
                chk("rsp_id_idle", 64'(rsp_id), 64'd0);
            end
            g  = es ? -1 : exp_grant(req_valid);
            er = '0;
            ea = '0;
            if (g >= 0) begin
                er[g] = 1'b1;
                ea    = req_data[32*g +: 32];
            end
            chk("req_ready", 64'(req_ready), 64'(er));
            chk("operand", 64'({a_sign, a_exp, a_man}), 64'(ea));
        end
    end

    // Model update at the active edge: issue pushes, retire pops
    initial forever begin
        @(posedge aclk);
        if (!rst_n) begin
            sbq.delete();
            ptr_m    = 0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            bit ev;
            int g;
            ev = exp_valid();
            if (!(ev && !rsp_ready)) begin
                if (ev) void'(sbq.pop_front());
                g = exp_grant(req_valid);
                if (g >= 0) begin
                    item_t it;
                    it.id = IDW'(g);
                    it.xv = fcos(req_data[32*g +: 32]);
                    it.e  = en_cnt;
                    sbq.push_back(it);
                    ptr_m = (g + 1) % NREQ;
                end
                en_cnt++;
            end
        end
    end

    // Requester-side state: valid held until accepted
    logic [NREQ-1:0] rv;
    logic [31:0]     rd [NREQ];

    task automatic apply();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]           = rv[i];
            req_data[32*i +: 32]   = rd[i];
        end
    endtask

    // One clock of stimulus: retire accepted operands, maybe raise new ones
    task automatic drive_cycle(input int p_raise, input int p_ready, input bit rst_v);
        logic [NREQ-1:0] acc;
        @(negedge aclk);
        acc = req_valid & req_ready;
        @(posedge aclk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i]) rv[i] = 1'b0;
            if (!rv[i] && ($urandom_range(99) < p_raise)) begin
                rv[i] = 1'b1;
                rd[i] = $urandom;
            end
        end
        rsp_ready = ($urandom_range(99) < p_ready);
        rst_n     = ~rst_v;
        apply();
    endtask

    task automatic run(input int n, input int p_raise, input int p_ready);
        for (int c = 0; c < n; c++) drive_cycle(p_raise, p_ready, 1'b0);
    endtask

    initial begin
        rv        = '0;
        for (int i = 0; i < NREQ; i++) rd[i] = '0;
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        apply();

        // Reset and idle
        repeat (2) @(posedge aclk);
        #1;
        rst_n = 1'b1;
        run(3, 0, 100);

        // Single request from requester 2 carrying 1.0
        rv[2] = 1'b1;
        rd[2] = 32'h3F80_0000;
        apply();
        run(6, 0, 100);

        // All requesters continuously valid
        for (int i = 0; i < NREQ; i++) begin
            rv[i] = 1'b1;
            rd[i] = $urandom;
        end
        apply();
        run(12, 100, 100);
        run(5, 0, 100);

        // Two results in flight, then 5 cycles of back-pressure
        rv[0] = 1'b1; rd[0] = $urandom;
        rv[1] = 1'b1; rd[1] = $urandom;
        apply();
        run(2, 0, 100);
        rv[3] = 1'b1; rd[3] = $urandom;
        apply();
        run(5, 0, 0);
        run(6, 0, 100);

        // Idle pipe with rsp_ready low still accepts until the tail fills
        rsp_ready = 1'b0;
        run(6, 100, 0);
        run(8, 0, 100);

        // Reset with two results in flight and the pointer at 3
        rv[1] = 1'b1; rd[1] = $urandom;
        apply();
        run(1, 0, 100);
        rv[2] = 1'b1; rd[2] = $urandom;
        apply();
        run(1, 0, 100);
        rv[1] = 1'b1; rd[1] = $urandom;
        rv[3] = 1'b1; rd[3] = $urandom;
        apply();
        drive_cycle(0, 100, 1'b1);
        run(6, 0, 100);

        // Randomized traffic with random back-pressure and occasional reset
        for (int c = 0; c < 400; c++) begin
            drive_cycle(40, 70, ($urandom_range(99) == 0));
        end

        // Drain
        rv = '0;
        apply();
        run(12, 0, 100);
        n_checks++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d results outstanding expected 0", sbq.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dft_cos_arbiter.md
# dft_cos_arbiter

Round-robin arbiter and scheduler that shares one pipelined single-precision cosine unit (`E8_M23`, registered-output variant, stall-capable) among `NREQ` requesters in the DFT compute path. It issues at most one operand per cycle into the unit and tracks requester IDs in a shadow valid/ID pipeline matched to the unit latency. It returns each result with its ID on a valid/ready response port, and drives the unit's `astall` to freeze it under response back-pressure.

## Interface
- `NREQ`, 4: number of requesters, 2..8
- `LAT`, 2: cosine unit latency in enabled cycles (operand to `x`)
- `IDW`, 3: response ID width; must satisfy 2^IDW >= NREQ
- `aclk` in 1: clock; all logic on rising edge
- `rst_n` in 1: reset, synchronous, active-low
- `req_valid` in NREQ: per-requester operand valid
- `req_ready` out NREQ: per-requester accept; one-hot or zero
- `req_data` in 32*NREQ: requester i operand in bits [32i+31:32i], packed as {sign, exp[7:0], man[22:0]}
- `a_sign` out 1: operand sign to the cosine unit
- `a_exp` out 8: operand exponent to the cosine unit
- `a_man` out 23: operand mantissa to the cosine unit
- `astall` out 1: freeze of the cosine unit pipeline
- `x` in 37: cosine unit result
- `rsp_valid` out 1: result valid
- `rsp_ready` in 1: consumer accept
- `rsp_id` out IDW: index of the originating requester
- `rsp_x` out 37: result, equal to `x`

## Operation
- Shadow pipe: `LAT` stages of {valid, id}. Each stage advances only when `astall`=0, in lockstep with the unit's internal registers. Tail stage = `out_v`/`out_id`.
- `astall` = `out_v & ~rsp_ready`. It is combinational and is the only stall source.
- `rsp_valid` = `out_v`. `rsp_id` = `out_id`. `rsp_x` = `x`. All three are combinational from the tail stage.
- Arbitration, when `astall`=0:
  - Grant the lowest index >= `rr_ptr` with `req_valid` set, wrapping modulo NREQ.
  - Assert `req_ready[g]` and drive `req_data[g]` onto `a_*`.
  - Shadow stage 0 loads {1, g}.
  - `rr_ptr` <= (g+1) mod NREQ.
- No valid requester, or `astall`=1:
  - `req_ready` = 0 and `a_*` = 0.
  - When `astall`=0, stage 0 loads {0, 0}.
  - `rr_ptr` holds.
- Transfer on a requester port occurs only when `req_valid[i] & req_ready[i]`. `req_ready` never depends on `rsp_ready` except through `astall`.
- Throughput: one issue and one retire per cycle while `rsp_ready`=1. No result is dropped or duplicated.
- Ordering: results retire in issue order.
- Fairness: a continuously valid requester is granted within NREQ issue cycles.

## Timing
- Latency: operand accepted at cycle t, with no stalls, gives `rsp_valid` at cycle t+LAT. Each stalled cycle adds one.
- Stall behaviour: during `astall`=1, `rsp_valid`, `rsp_id` and `rsp_x` stay stable until accepted.
- Reset (`rst_n`=0 at an edge):
  - All shadow valids and IDs clear; `rr_ptr` = 0.
  - Next cycle outputs: `rsp_valid`=0, `rsp_id`=0, `astall`=0, `req_ready`=0 while `req_valid`=0.
  - `rsp_x` follows `x` (don't-care while `rsp_valid`=0).
- Mid-operation reset: in-flight results are discarded. Unit register contents are ignored because valids are cleared. The first grant after reset starts from index 0.
- Simultaneous stall and new request: no grant that cycle. The request stays pending with `req_valid` held by the requester.
- Bubble retire: `out_v`=0 never stalls, regardless of `rsp_ready`.

## Configuration
- `DFT_COS_ARB_PERF_EN` defined: adds outputs `perf_issue`[31:0] (count of granted operands) and `perf_stall`[31:0] (count of cycles with `astall`=1).
  - Both counters clear on reset and wrap at 2^32.
- Undefined: those ports and counters do not exist; all other behaviour is identical.

## Test plan
- Single request, NREQ=4, LAT=2: req 2 sends {0, 0x7F, 0} (1.0) with `rsp_ready`=1 -> `rsp_valid` exactly 2 cycles after accept, `rsp_id`=2, `rsp_x` equals the unit's cos(1.0) value.
- All four requesters continuously valid, `rsp_ready`=1, 12 cycles after reset -> grants 0,1,2,3,0,1,2,3,...; `rsp_id` sequence identical, delayed by 2 cycles; one response per cycle.
- Back-pressure: hold `rsp_ready`=0 for 5 cycles with 2 results in flight -> `astall`=1 for those 5 cycles, no `req_ready`, `rsp_*` stable. After release, both results retire in order on consecutive cycles with no loss.
- Idle pipe with `rsp_ready`=0 -> `astall`=0; new requests are still accepted until the first result reaches the tail.
- Reset asserted with 2 results in flight and `rr_ptr`=3 -> no `rsp_valid` afterwards for those results; the next grant goes to the lowest valid index from 0.
- With `DFT_COS_ARB_PERF_EN`: 10 issues and 5 stall cycles -> `perf_issue`=10 and `perf_stall`=5; both read 0 after reset.
